// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Optional MDU_DIVZERO_EN: divz flag output and short-cut divide-by-zero path.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_EN
    ,
    output logic             divz
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]      acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;
    logic                  busy_q, busy_d, done_q, done_d;
`ifdef MDU_DIVZERO_EN
    logic                  divz_q, divz_d;
`endif

    logic                  is_div, is_signed, sa, sb;
    logic [WIDTH-1:0]      a_mag, b_mag;
    logic [WIDTH:0]        mterm, msum, dshift, ddiff;
    logic [2*WIDTH-1:0]    prod, prod_neg;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign sa        = is_signed & a_q[WIDTH-1];
    assign sb        = is_signed & b_q[WIDTH-1];
    assign a_mag     = sa ? -a_q : a_q;
    assign b_mag     = sb ? -b_q : b_q;

    // Shift-add step: conditional add into the upper half, then shift the pair right.
    assign mterm     = acc_lo_q[0] ? {1'b0, opnd_q} : '0;
    assign msum      = {1'b0, acc_hi_q} + mterm;

    // Restoring step: partial remainder is always below 2*divisor, so WIDTH+1 bits hold the sign.
    assign dshift    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign ddiff     = dshift - {1'b0, opnd_q};

    assign prod      = {acc_hi_q, acc_lo_q};
    assign prod_neg  = -prod;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef MDU_DIVZERO_EN
        divz_d   = divz_q;
`endif

        if (!busy_q && hi_wr) hi_d = wdata;
        if (!busy_q && lo_wr) lo_d = wdata;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
`ifdef MDU_DIVZERO_EN
                    divz_d  = 1'b0;
                    if (op[1] && b == '0) state_d = S_FIX;
`endif
                end
            end
            S_PREP: begin
                acc_hi_d = '0;
                acc_lo_d = is_div ? a_mag : b_mag;
                opnd_d   = is_div ? b_mag : a_mag;
                qneg_d   = sa ^ sb;
                rneg_d   = is_div & sa;
                cnt_d    = CW'(WIDTH - 1);
                state_d  = S_CALC;
            end
            S_CALC: begin
                if (is_div) begin
                    acc_hi_d = ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~ddiff[WIDTH]};
                end else begin
                    acc_hi_d = msum[WIDTH:1];
                    acc_lo_d = {msum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div && b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
`ifdef MDU_DIVZERO_EN
                    divz_d = 1'b1;
`endif
                end else if (is_div) begin
                    lo_d = qneg_q ? -acc_lo_q : acc_lo_q;
                    hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = qneg_q ? prod_neg : prod;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef MDU_DIVZERO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) divz_q <= 1'b0;
        else      divz_q <= divz_d;
    end
    assign divz = divz_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk, rst, start, hi_wr, lo_wr;
    logic [1:0]  op;
    logic [31:0] a, b, wdata, hi, lo;
    logic        busy, done;
`ifdef MDU_DIVZERO_EN
    logic        divz;
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 35;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIVZERO_EN
        , .divz(divz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"},  hi, e.hi);
                chk({e.name, "_lo"},  lo, e.lo);
                chk({e.name, "_lat"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                         input string nm);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        e.hi  = ehi;
        e.lo  = elo;
        e.cyc = cyc + lat;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 35, "mult_m3x7");
        wait_done();
        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 35, "multu_max_x2");
        wait_done();
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 35, "divu_100_7");
        wait_done();
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, "div_m7_2");
        wait_done();
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 35, "div_min_m1");
        wait_done();
        @(negedge clk);
        issue(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DZ_LAT, "divu_5_0");
        wait_done();
`ifdef MDU_DIVZERO_EN
        chk("divz_set", {31'd0, divz}, 32'd1);
`endif
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DZ_LAT, "div_m5_0");
        wait_done();
        @(negedge clk);

        // Start and MTLO while busy must both be dropped.
        issue(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 35, "mult_3x5");
`ifdef MDU_DIVZERO_EN
        chk("divz_clear", {31'd0, divz}, 32'd0);
`endif
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; lo_wr = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; lo_wr = 1'b0;
        chk("busy_lo_wr_ignored", lo, 32'hFFFF_FFFF);
        chk("busy_held", {31'd0, busy}, 32'd1);
        wait_done();
        repeat (40) @(negedge clk);

        lo_wr = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_wr = 1'b0;
        chk("idle_lo_wr", lo, 32'h1234);
        chk("idle_lo_wr_hi", hi, 32'd0);

        hi_wr = 1'b1; wdata = 32'h55;
        issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 35, "mult_2x3_with_mthi");
        hi_wr = 1'b0;
        chk("mthi_with_start", hi, 32'h55);
        wait_done();
        @(negedge clk);

        // Asynchronous reset mid-calculation discards the operation.
        issue(2'b00, 32'd100, 32'd100, 32'd0, 32'd10000, 35, "mult_aborted");
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 35, "mult_6x7");
        wait_done();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
